random_slicer: RTL and testbench
================================

RANDOM_SLICER -- requirements
Module: random_slicer

Interface
REQ-001 Parameter DEPTH_LOG2, default 2; word FIFO holds 2**DEPTH_LOG2 words of 64 bits; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rand_word  input  64  random word from the upstream LFSR stage.
REQ-005 rand_avail  input  1  one-cycle strobe; rand_word is valid in the same cycle.
REQ-006 lfsr_ce  output  1  shift enable to the LFSR; high when the FIFO is not full and flush is low.
REQ-007 flush  input  1  discards all buffered bits; pulsed alongside an LFSR reseed.
REQ-008 width_sel  input  6  requested slice width; 0 is treated as 1, values above 32 are treated as 32.
REQ-009 rd_req  input  1  one-cycle request for one slice.
REQ-010 rd_data  output  32  slice value, zero-extended above the effective width.
REQ-011 rd_valid  output  1  one-cycle strobe; rd_data is valid in the same cycle.
REQ-012 rd_busy  output  1  high while a request is pending and unserved.
REQ-013 underflow  output  1  sticky flag; set when a pending request finds both the working register and the FIFO empty.
REQ-014 fifo_count  output  DEPTH_LOG2+1  number of words currently in the FIFO.

Function
REQ-015 Push: rand_avail with FIFO not full writes rand_word; rand_avail with FIFO full drops the word, and fifo_count is unchanged.
REQ-016 A push and a pop in the same cycle shall both be honoured, including when the FIFO is full, and fifo_count is then unchanged.
REQ-017 Working register: 64-bit shift register plus bits_left (0..64); each slice is taken from the LSBs and the register then shifts right by the effective width W.
REQ-018 FSM states: EMPTY, READY, LOAD.
REQ-019 EMPTY: if the FIFO is non-empty, pop one word into the working register, set bits_left=64 and go to READY; otherwise stay in EMPTY.
REQ-020 READY with rd_req and W<=bits_left: next cycle rd_valid=1 and rd_data = the low W bits; bits_left decrements by W; if bits_left reaches 0, go to EMPTY.
REQ-021 READY with rd_req and W>bits_left: discard the leftover bits, set pending, assert rd_busy and go to LOAD; leftover bits are never concatenated with new bits.
REQ-022 LOAD with FIFO non-empty: pop one word into the working register, bits_left=64; the pending request is served from the new word, with rd_valid on the following cycle; clear pending; go to READY, or to EMPTY if the slice consumed all 64 bits.
REQ-023 LOAD with FIFO empty: set underflow and remain in LOAD until a word arrives; a push and a pop of the same word in one cycle are permitted (FIFO pass-through).
REQ-024 rd_req in EMPTY sets pending, asserts rd_busy and goes to LOAD.
REQ-025 rd_req while rd_busy=1 is ignored: no queuing and no additional rd_valid.
REQ-026 Latency: in READY with sufficient bits, rd_valid follows rd_req by exactly 1 cycle; a request that needs a refill from a non-empty FIFO is served in exactly 2 cycles.
REQ-027 width_sel is sampled in the same cycle as rd_req, or when entering pending; later changes do not affect that request.
REQ-028 flush: next cycle the FIFO is empty, bits_left=0, pending is cleared, rd_busy=0, the state is EMPTY, and no rd_valid is produced for a cancelled request.
REQ-029 flush has priority over push, pop and rd_req in the same cycle; a rand_avail coincident with flush is dropped; underflow is not cleared by flush.
REQ-030 lfsr_ce is combinational from FIFO-full and flush.

Reset
REQ-031 rst has priority over all inputs, including flush.
REQ-032 After rst, the following outputs are 0: rd_data, rd_valid, rd_busy, underflow, fifo_count.
REQ-033 After rst, the state is EMPTY, bits_left=0 and the working register is 0.
REQ-034 Reset mid-operation abandons any pending request without producing an rd_valid strobe.
REQ-035 lfsr_ce is 1 in the cycle after rst deasserts.

Configuration
REQ-036 Macro RANDOM_SLICER_THRESH_EN, when defined, adds input thresh (32) and output rd_hit (1).
REQ-037 With the macro defined, rd_hit=1 exactly when the served slice value is less than thresh (unsigned), and rd_hit is valid only alongside rd_valid; thresh is sampled with rd_req.
REQ-038 With the macro defined, rd_hit resets to 0.
REQ-039 Without RANDOM_SLICER_THRESH_EN, neither port exists and no comparator logic is generated; all other behaviour is identical.

Verification
REQ-040 Reset, push 64'h0123_4567_89AB_CDEF, width_sel=8, four rd_req in READY -> rd_data 0xEF, 0xCD, 0xAB, 0x89, each 1 cycle after its request.
REQ-041 width_sel=40 with bits_left=64 -> W=32, rd_data=32'h89AB_CDEF; width_sel=0 -> W=1.
REQ-042 bits_left=8, width_sel=16, second word 64'hFFFF_0000_0000_1234 queued -> rd_busy for 1 cycle, rd_data=0x1234 at 2 cycles; leftover 8 bits discarded.
REQ-043 FIFO empty, rd_req -> underflow=1 and rd_busy held; push any word -> rd_valid, then rd_busy=0; underflow remains 1.
REQ-044 DEPTH_LOG2=2, five consecutive rand_avail with no reads -> fifo_count=4, fifth word dropped, lfsr_ce=0; one pop -> lfsr_ce=1.
REQ-045 Pending request plus flush in the same cycle -> no rd_valid, state EMPTY, fifo_count=0; with RANDOM_SLICER_THRESH_EN, thresh=0x80, slice 0x7F -> rd_hit=1, and slice 0x80 -> rd_hit=0.

Source files
------------

// File: rtl/random_slicer.sv
// Slices a stream of 64-bit random words into 1..32-bit values on request.
// Defining RANDOM_SLICER_THRESH_EN adds a threshold input (thresh) and a compare output (rd_hit).
module random_slicer #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           rand_word,
  input  logic                  rand_avail,
  output logic                  lfsr_ce,
  input  logic                  flush,
  input  logic [5:0]            width_sel,
  input  logic                  rd_req,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic                  rd_busy,
  output logic                  underflow,
  output logic [DEPTH_LOG2:0]   fifo_count
`ifdef RANDOM_SLICER_THRESH_EN
  ,
  input  logic [31:0]           thresh,
  output logic                  rd_hit
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {S_EMPTY, S_READY, S_LOAD} state_t;

  logic [63:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;

  state_t      state_q;
  logic [63:0] work_q;
  logic [6:0]  bits_q;
  logic        pend_q;
  logic [5:0]  pend_w_q;
  logic        underflow_q;
  logic [31:0] rd_data_q;
  logic        rd_valid_q;

  logic        fifo_empty, fifo_full, word_avail;
  logic [63:0] head;
  logic [5:0]  req_w, take_w;
  logic [63:0] take_src;
  logic [31:0] serve_val;
  logic        fits, serve_fire, enter_pend, pop, fifo_pop, push;

  function automatic logic [31:0] low_bits(input logic [63:0] w, input logic [5:0] n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return 32'(w & m);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  // An empty FIFO lets a same-cycle incoming word straight through to a waiting request.
  assign head       = fifo_empty ? rand_word : mem_q[rd_ptr_q];
  assign word_avail = !fifo_empty || rand_avail;

  always_comb begin
    req_w = width_sel;
    if (width_sel == 6'd0)       req_w = 6'd1;
    else if (width_sel > 6'd32)  req_w = 6'd32;
  end

  assign fits       = ({1'b0, req_w} <= bits_q);
  assign take_w     = (state_q == S_LOAD) ? pend_w_q : req_w;
  assign take_src   = (state_q == S_LOAD) ? head : work_q;
  assign serve_val  = low_bits(take_src, take_w);
  assign serve_fire = !flush && (((state_q == S_READY) && rd_req && fits) ||
                                 ((state_q == S_LOAD) && word_avail));
  assign enter_pend = !flush && rd_req &&
                      ((state_q == S_EMPTY) || ((state_q == S_READY) && !fits));

  assign pop      = !flush && (((state_q == S_EMPTY) && !rd_req && !fifo_empty) ||
                               ((state_q == S_LOAD) && word_avail));
  assign fifo_pop = pop && !fifo_empty;
  assign push     = rand_avail && !flush && (!fifo_full || pop) && !(pop && fifo_empty);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rand_word;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)     wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, fifo_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      work_q      <= '0;
      bits_q      <= '0;
      pend_q      <= 1'b0;
      pend_w_q    <= '0;
      underflow_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (serve_fire) begin
        rd_data_q  <= serve_val;
        rd_valid_q <= 1'b1;
      end
      if (enter_pend) pend_w_q <= req_w;
      if (flush) begin
        state_q <= S_EMPTY;
        work_q  <= '0;
        bits_q  <= '0;
        pend_q  <= 1'b0;
      end else begin
        case (state_q)
          S_EMPTY: begin
            if (rd_req) begin
              pend_q  <= 1'b1;
              state_q <= S_LOAD;
            end else if (!fifo_empty) begin
              work_q  <= head;
              bits_q  <= 7'd64;
              state_q <= S_READY;
            end
          end
          S_READY: begin
            if (rd_req && fits) begin
              work_q <= work_q >> req_w;
              bits_q <= bits_q - {1'b0, req_w};
              if (bits_q == {1'b0, req_w}) state_q <= S_EMPTY;
            end else if (rd_req) begin
              // Leftover bits are dropped rather than stitched to the next word.
              work_q  <= '0;
              bits_q  <= '0;
              pend_q  <= 1'b1;
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            if (fifo_empty) underflow_q <= 1'b1;
            if (word_avail) begin
              work_q  <= head >> pend_w_q;
              bits_q  <= 7'd64 - {1'b0, pend_w_q};
              pend_q  <= 1'b0;
              state_q <= (pend_w_q == 6'd0) ? S_EMPTY : S_READY;
            end
          end
          default: state_q <= S_EMPTY;
        endcase
      end
    end
  end

`ifdef RANDOM_SLICER_THRESH_EN
  logic [31:0] pend_thr_q;
  logic [31:0] cur_thr;
  logic        rd_hit_q;

  assign cur_thr = (state_q == S_LOAD) ? pend_thr_q : thresh;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_thr_q <= '0;
      rd_hit_q   <= 1'b0;
    end else begin
      rd_hit_q <= serve_fire && (serve_val < cur_thr);
      if (enter_pend) pend_thr_q <= thresh;
    end
  end

  assign rd_hit = rd_hit_q;
`endif

  assign lfsr_ce    = !fifo_full && !flush;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_busy    = pend_q;
  assign underflow  = underflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_random_slicer.sv
// Self-checking bench for random_slicer: directed scenarios then random traffic,
// each cycle compared against a queue-based behavioural model.
module tb_random_slicer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, rand_avail, flush, rd_req;
  logic [63:0] rand_word;
  logic [5:0]  width_sel;
  logic        lfsr_ce, rd_valid, rd_busy, underflow;
  logic [31:0] rd_data;
  logic [2:0]  fifo_count;
`ifdef RANDOM_SLICER_THRESH_EN
  logic [31:0] thresh;
  logic        rd_hit;
`endif

  always #5 clk = ~clk;

  random_slicer #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst), .rand_word(rand_word), .rand_avail(rand_avail),
    .lfsr_ce(lfsr_ce), .flush(flush), .width_sel(width_sel), .rd_req(rd_req),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
    .underflow(underflow), .fifo_count(fifo_count)
`ifdef RANDOM_SLICER_THRESH_EN
    , .thresh(thresh), .rd_hit(rd_hit)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Behavioural model: queue of buffered words plus a bit reservoir.
  logic [63:0] mq[$];
  logic [63:0] m_work;
  int          m_bits;
  bit          m_pend;
  int          m_pw;
  logic [31:0] m_pthr;
  bit          m_uf;
  logic [31:0] m_rdata;
  bit          e_valid;
  bit          e_hit;

  function automatic int eff(input logic [5:0] s);
    if (s == 6'd0) return 1;
    if (s > 6'd32) return 32;
    return int'(s);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_work = '0; m_bits = 0; m_pend = 0; m_pw = 0; m_pthr = '0;
    m_uf = 0; m_rdata = '0; e_valid = 0; e_hit = 0;
  endtask

  task automatic serve(input logic [63:0] w, input int n, input logic [31:0] th);
    logic [63:0] v;
    v = w % (64'd1 << n);
    m_rdata = v[31:0];
    e_valid = 1;
    e_hit   = (m_rdata < th);
  endtask

  task automatic model_step(input bit av, input logic [63:0] wd, input bit fl,
                            input logic [5:0] ws, input bit rq, input logic [31:0] th);
    bit consumed;
    logic [63:0] w;
    int n;
    e_valid = 0; e_hit = 0; consumed = 0;
    if (fl) begin
      mq.delete(); m_bits = 0; m_work = '0; m_pend = 0;
      return;
    end
    if (m_pend) begin
      if (mq.size() == 0) m_uf = 1;
      if (mq.size() > 0 || av) begin
        if (mq.size() > 0) w = mq.pop_front();
        else begin w = wd; consumed = 1; end
        serve(w, m_pw, m_pthr);
        m_work = w >> m_pw; m_bits = 64 - m_pw; m_pend = 0;
      end
    end else if (m_bits == 0) begin
      if (rq) begin m_pend = 1; m_pw = eff(ws); m_pthr = th; end
      else if (mq.size() > 0) begin m_work = mq.pop_front(); m_bits = 64; end
    end else if (rq) begin
      n = eff(ws);
      if (n <= m_bits) begin
        serve(m_work, n, th);
        m_work = m_work >> n; m_bits = m_bits - n;
      end else begin
        m_bits = 0; m_pend = 1; m_pw = n; m_pthr = th;
      end
    end
    if (av && !consumed && mq.size() < DEPTH) mq.push_back(wd);
  endtask

  task automatic check_all();
    chk("rd_valid", 64'(rd_valid), 64'(e_valid));
    chk("rd_data", 64'(rd_data), 64'(m_rdata));
    chk("rd_busy", 64'(rd_busy), 64'(m_pend));
    chk("underflow", 64'(underflow), 64'(m_uf));
    chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
    chk("lfsr_ce", 64'(lfsr_ce), 64'(mq.size() < DEPTH));
`ifdef RANDOM_SLICER_THRESH_EN
    if (e_valid) chk("rd_hit", 64'(rd_hit), 64'(e_hit));
`endif
  endtask

  task automatic step(input bit av, input logic [63:0] wd, input bit fl,
                      input logic [5:0] ws, input bit rq, input logic [31:0] th);
    rand_avail = av; rand_word = wd; flush = fl; width_sel = ws; rd_req = rq;
`ifdef RANDOM_SLICER_THRESH_EN
    thresh = th;
`endif
    @(posedge clk); #1;
    model_step(av, wd, fl, ws, rq, th);
    rand_avail = 0; flush = 0; rd_req = 0;
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 64'd0, 0, 6'd8, 0, 32'd0);
  endtask

  task automatic push(input logic [63:0] wd);
    step(1, wd, 0, 6'd8, 0, 32'd0);
  endtask

  task automatic req(input logic [5:0] ws);
    step(0, 64'd0, 0, ws, 1, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1; rand_avail = 0; flush = 0; rd_req = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    model_reset();
    #1;
    check_all();
    chk("lfsr_ce_after_rst", 64'(lfsr_ce), 64'd1);
  endtask

  initial begin
    rst = 1; rand_avail = 0; flush = 0; rd_req = 0; rand_word = '0; width_sel = 6'd8;
`ifdef RANDOM_SLICER_THRESH_EN
    thresh = '0;
`endif
    model_reset();

    // Reset state and four byte slices from one word.
    do_reset();
    push(64'h0123_4567_89AB_CDEF); idle(); idle();
    req(6'd8); chk("byte0", 64'(rd_data), 64'h EF); chk("byte0_v", 64'(rd_valid), 64'd1);
    req(6'd8); chk("byte1", 64'(rd_data), 64'h CD);
    req(6'd8); chk("byte2", 64'(rd_data), 64'h AB);
    req(6'd8); chk("byte3", 64'(rd_data), 64'h 89);

    // Width clamping: 40 -> 32, 0 -> 1.
    do_reset();
    push(64'h0123_4567_89AB_CDEF); idle(); idle();
    req(6'd40); chk("w40", 64'(rd_data), 64'h89AB_CDEF);
    req(6'd0);  chk("w0", 64'(rd_data), 64'd1);

    // Refill: leftover 8 bits discarded, second word serves the request.
    do_reset();
    push(64'h0123_4567_89AB_CDEF); push(64'hFFFF_0000_0000_1234); idle();
    req(6'd32); req(6'd24);
    req(6'd16); chk("refill_busy", 64'(rd_busy), 64'd1); chk("refill_nv", 64'(rd_valid), 64'd0);
    idle(); chk("refill_data", 64'(rd_data), 64'h1234); chk("refill_v", 64'(rd_valid), 64'd1);
    chk("refill_busy0", 64'(rd_busy), 64'd0);

    // Underflow with pass-through word.
    do_reset();
    req(6'd8); idle(); idle();
    chk("uf_set", 64'(underflow), 64'd1); chk("uf_busy", 64'(rd_busy), 64'd1);
    push(64'h55); chk("uf_data", 64'(rd_data), 64'h55); chk("uf_busy0", 64'(rd_busy), 64'd0);
    idle(); chk("uf_sticky", 64'(underflow), 64'd1);

    // Fill FIFO behind a loaded working register.
    do_reset();
    push(64'hAAAA_AAAA_AAAA_AAAA); idle(); idle();
    for (int i = 0; i < 5; i++) push(64'h1000 + 64'(i));
    chk("full_cnt", 64'(fifo_count), 64'd4); chk("full_ce", 64'(lfsr_ce), 64'd0);
    req(6'd32); req(6'd32); idle();
    chk("pop_cnt", 64'(fifo_count), 64'd3); chk("pop_ce", 64'(lfsr_ce), 64'd1);

    // Flush cancels a pending request.
    do_reset();
    req(6'd8);
    step(1, 64'h77, 1, 6'd8, 1, 32'd0);
    chk("fl_nv", 64'(rd_valid), 64'd0); chk("fl_cnt", 64'(fifo_count), 64'd0);
    chk("fl_busy", 64'(rd_busy), 64'd0);
    idle(); chk("fl_nv2", 64'(rd_valid), 64'd0);
    push(64'h1); push(64'h2); push(64'h3);
    step(0, 64'd0, 1, 6'd8, 0, 32'd0); chk("fl_cnt2", 64'(fifo_count), 64'd0);

`ifdef RANDOM_SLICER_THRESH_EN
    do_reset();
    push(64'h807F); idle(); idle();
    step(0, 64'd0, 0, 6'd8, 1, 32'h80); chk("hit_7f", 64'(rd_hit), 64'd1);
    step(0, 64'd0, 0, 6'd8, 1, 32'h80); chk("hit_80", 64'(rd_hit), 64'd0);
`endif

    // Random traffic, including occasional mid-operation reset.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 2) == 0), {$urandom, $urandom},
             ($urandom_range(0, 63) == 0), 6'($urandom_range(0, 63)),
             ($urandom_range(0, 2) == 0), $urandom_range(0, 255));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
